// File: rtl/app_if_pkg.sv
// Shared definitions for the SPI master: register offsets, CTRL/STATUS bit
// positions and the transfer FSM encoding.
package app_if_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_TXDATA = 2'd1;
  localparam logic [1:0] REG_RXDATA = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_START   = 0;
  localparam int CTRL_CS_SEL  = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_LEN_LSB = 8;
  localparam int CTRL_LEN_MSB = 12;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_CS_HOLD  = 3'd4
  } spi_state_e;

endpackage

// File: rtl/app_spi_clkgen.sv
// Phase-tick generator: tick_o pulses on the last cycle of every CLK_DIV-cycle
// phase while enabled; the counter sits at zero whenever disabled.
module app_spi_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (!en_i || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/app_spi_master.sv
// OPB-attached mode-0 SPI master driving two chip selects off one shared SCLK;
// register file, transfer FSM and shift registers live here.
module app_spi_master
  import app_if_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CLK_DIV    = 4
) (
  input  logic                  OPB_CLK,
  input  logic                  OPB_RST_N,
  input  logic [DATA_WIDTH-1:0] OPB_DI,
  output logic [DATA_WIDTH-1:0] OPB_DO,
  input  logic [31:0]           OPB_ADDR,
  input  logic                  APP_RE,
  input  logic                  APP_WE,
  output logic                  APP_FPGA_SPI_CLK,
  output logic                  APP_FPGA_SPI0_CS_N,
  output logic                  APP_FPGA_SPI1_CS_N,
  output logic                  APP_FPGA_SPI0_MOSI,
  output logic                  APP_FPGA_SPI1_MOSI,
  input  logic                  APP_FPGA_SPI0_MISO,
  input  logic                  APP_FPGA_SPI1_MISO,
  output logic                  SPI_IRQ
);

  spi_state_e state_q, state_d;

  logic                  tick, busy;
  logic [1:0]            reg_sel;
  logic                  unused_addr;
  logic                  wr_ctrl, wr_tx, start, rx_read;
  logic                  sclk_rise, bit_end, xfer_end;
  logic                  miso_bit, mosi_bit;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  ctrl_cs_sel_q, ctrl_irq_en_q;
  logic [4:0]            ctrl_len_q;
  logic [DATA_WIDTH-1:0] txdata_q, rxdata_q, do_q;
  logic                  done_q;
  logic                  xfer_sel_q;
  logic [4:0]            xfer_len_q, bit_cnt_q;
  logic [DATA_WIDTH-1:0] tx_sh_q, rx_sh_q;

  assign reg_sel     = OPB_ADDR[3:2];
  assign unused_addr = ^{OPB_ADDR[31:4], OPB_ADDR[1:0]};
  assign busy        = (state_q != ST_IDLE);

  // Every register write is dropped while a transfer is in flight.
  assign wr_ctrl   = APP_WE && !busy && (reg_sel == REG_CTRL);
  assign wr_tx     = APP_WE && !busy && (reg_sel == REG_TXDATA);
  assign start     = wr_ctrl && OPB_DI[CTRL_START];
  assign rx_read   = APP_RE && (reg_sel == REG_RXDATA);
  assign sclk_rise = (state_q == ST_SHIFT_LO) && tick;
  assign bit_end   = (state_q == ST_SHIFT_HI) && tick;
  assign xfer_end  = (state_q == ST_CS_HOLD) && tick;
  assign miso_bit  = xfer_sel_q ? APP_FPGA_SPI1_MISO : APP_FPGA_SPI0_MISO;

  app_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk_i   (OPB_CLK),
    .rst_n_i (OPB_RST_N),
    .en_i    (busy),
    .tick_o  (tick)
  );

  always_ff @(posedge OPB_CLK) begin
    if (!OPB_RST_N) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    mosi_bit           = 1'b0;
    APP_FPGA_SPI_CLK   = 1'b0;
    APP_FPGA_SPI0_CS_N = 1'b1;
    APP_FPGA_SPI1_CS_N = 1'b1;
    unique case (state_q)
      ST_IDLE:     if (start) state_d = ST_CS_SETUP;
      ST_CS_SETUP: if (tick) state_d = ST_SHIFT_LO;
      ST_SHIFT_LO: if (tick) state_d = ST_SHIFT_HI;
      ST_SHIFT_HI: if (tick) state_d = (bit_cnt_q == xfer_len_q) ? ST_CS_HOLD : ST_SHIFT_LO;
      ST_CS_HOLD:  if (tick) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    if (busy) begin
      APP_FPGA_SPI0_CS_N = xfer_sel_q;
      APP_FPGA_SPI1_CS_N = !xfer_sel_q;
    end
    if (state_q == ST_SHIFT_LO || state_q == ST_SHIFT_HI) mosi_bit = tx_sh_q[DATA_WIDTH-1];
    APP_FPGA_SPI_CLK = (state_q == ST_SHIFT_HI);
  end

  assign APP_FPGA_SPI0_MOSI = mosi_bit && !xfer_sel_q;
  assign APP_FPGA_SPI1_MOSI = mosi_bit && xfer_sel_q;

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_CTRL: begin
        rd_data[CTRL_CS_SEL]                = ctrl_cs_sel_q;
        rd_data[CTRL_IRQ_EN]                = ctrl_irq_en_q;
        rd_data[CTRL_LEN_MSB:CTRL_LEN_LSB]  = ctrl_len_q;
      end
      REG_TXDATA: rd_data = txdata_q;
      REG_RXDATA: rd_data = rxdata_q;
      default: begin
        rd_data[STAT_BUSY] = busy;
        rd_data[STAT_DONE] = done_q;
      end
    endcase
  end

  always_ff @(posedge OPB_CLK) begin
    if (!OPB_RST_N) begin
      ctrl_cs_sel_q <= 1'b0;
      ctrl_irq_en_q <= 1'b0;
      ctrl_len_q    <= '0;
      txdata_q      <= '0;
      rxdata_q      <= '0;
      do_q          <= '0;
      done_q        <= 1'b0;
      xfer_sel_q    <= 1'b0;
      xfer_len_q    <= '0;
      bit_cnt_q     <= '0;
      tx_sh_q       <= '0;
      rx_sh_q       <= '0;
    end else begin
      if (APP_RE) do_q <= rd_data;
      if (wr_tx) txdata_q <= OPB_DI;
      if (wr_ctrl) begin
        ctrl_cs_sel_q <= OPB_DI[CTRL_CS_SEL];
        ctrl_irq_en_q <= OPB_DI[CTRL_IRQ_EN];
        ctrl_len_q    <= OPB_DI[CTRL_LEN_MSB:CTRL_LEN_LSB];
      end
      // Left-align the N payload bits so MOSI always comes from the MSB.
      if (start) begin
        xfer_sel_q <= OPB_DI[CTRL_CS_SEL];
        xfer_len_q <= OPB_DI[CTRL_LEN_MSB:CTRL_LEN_LSB];
        bit_cnt_q  <= '0;
        tx_sh_q    <= txdata_q << (DATA_WIDTH - 1 - int'(OPB_DI[CTRL_LEN_MSB:CTRL_LEN_LSB]));
        rx_sh_q    <= '0;
      end
      if (sclk_rise) rx_sh_q <= {rx_sh_q[DATA_WIDTH-2:0], miso_bit};
      if (bit_end) begin
        tx_sh_q   <= tx_sh_q << 1;
        bit_cnt_q <= bit_cnt_q + 5'd1;
      end
      if (xfer_end) rxdata_q <= rx_sh_q;
      // Completion wins over a coincident RXDATA read.
      if (xfer_end)     done_q <= 1'b1;
      else if (rx_read) done_q <= 1'b0;
    end
  end

  assign OPB_DO  = do_q;
  assign SPI_IRQ = done_q && ctrl_irq_en_q;

endmodule

// File: tb/tb_app_spi_master.sv
// Directed bench for app_spi_master: two instances (CLK_DIV=4 and CLK_DIV=1),
// expectations queued on a scoreboard and popped when the DUT result appears.
module tb_app_spi_master;
  import app_if_pkg::*;

  logic        clk;
  logic        OPB_RST_N;
  logic [31:0] addr, di;
  logic        we0, re0, we1, re1;

  logic [31:0] d0_do, d1_do;
  logic        d0_sclk, d0_cs0_n, d0_cs1_n, d0_mosi0, d0_mosi1, d0_miso1, d0_irq;
  logic        d1_sclk, d1_cs0_n, d1_cs1_n, d1_mosi0, d1_mosi1, d1_miso1, d1_irq;
  wire         d0_miso0 = d0_mosi0;
  wire         d1_miso0 = d1_mosi0;

  app_spi_master #(.DATA_WIDTH(32), .CLK_DIV(4)) u_dut0 (
    .OPB_CLK(clk), .OPB_RST_N(OPB_RST_N), .OPB_DI(di), .OPB_DO(d0_do), .OPB_ADDR(addr),
    .APP_RE(re0), .APP_WE(we0), .APP_FPGA_SPI_CLK(d0_sclk),
    .APP_FPGA_SPI0_CS_N(d0_cs0_n), .APP_FPGA_SPI1_CS_N(d0_cs1_n),
    .APP_FPGA_SPI0_MOSI(d0_mosi0), .APP_FPGA_SPI1_MOSI(d0_mosi1),
    .APP_FPGA_SPI0_MISO(d0_miso0), .APP_FPGA_SPI1_MISO(d0_miso1), .SPI_IRQ(d0_irq)
  );

  app_spi_master #(.DATA_WIDTH(32), .CLK_DIV(1)) u_dut1 (
    .OPB_CLK(clk), .OPB_RST_N(OPB_RST_N), .OPB_DI(di), .OPB_DO(d1_do), .OPB_ADDR(addr),
    .APP_RE(re1), .APP_WE(we1), .APP_FPGA_SPI_CLK(d1_sclk),
    .APP_FPGA_SPI0_CS_N(d1_cs0_n), .APP_FPGA_SPI1_CS_N(d1_cs1_n),
    .APP_FPGA_SPI0_MOSI(d1_mosi0), .APP_FPGA_SPI1_MOSI(d1_mosi1),
    .APP_FPGA_SPI0_MISO(d1_miso0), .APP_FPGA_SPI1_MISO(d1_miso1), .SPI_IRQ(d1_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  string       tag_q[$];
  logic [31:0] val_q[$];

  // Pin monitors, sampled on the falling edge.
  int          busy0 = 0, cs0lo0 = 0, cs1lo0 = 0, m0hi0 = 0, m1hi0 = 0, edges0 = 0, rises0 = 0;
  int          busy1 = 0, rises1 = 0, sclkhi1 = 0;
  logic [31:0] cap0 = '0;
  logic        prev0 = 1'b0, prev1 = 1'b0;
  logic [31:0] rx_pat = '0;
  logic [31:0] pat_sh;
  int          rise_base = 0, b_busy0 = 0, b_cs0lo = 0, b_cs1lo = 0, b_m0hi = 0, b_m1hi = 0, b_edges0 = 0;
  int          b_busy1 = 0, b_rises1 = 0, b_sclkhi1 = 0;

  always @(negedge clk) begin
    if (!d0_cs0_n || !d0_cs1_n) busy0++;
    if (!d0_cs0_n) cs0lo0++;
    if (!d0_cs1_n) cs1lo0++;
    if (d0_mosi0) m0hi0++;
    if (d0_mosi1) m1hi0++;
    if (d0_sclk !== prev0) edges0++;
    if (d0_sclk && !prev0) begin
      rises0++;
      cap0 = {cap0[30:0], d0_mosi0 | d0_mosi1};
    end
    prev0 = d0_sclk;
    // SPI1 slave model presents the pattern MSB first, advancing after each rise.
    pat_sh = rx_pat << (rises0 - rise_base);
    d0_miso1 = pat_sh[31];
  end

  always @(negedge clk) begin
    if (!d1_cs0_n || !d1_cs1_n) busy1++;
    if (d1_sclk) sclkhi1++;
    if (d1_sclk && !prev1) rises1++;
    prev1 = d1_sclk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic sb_push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (val_q.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%h", obs);
      return;
    end
    t = tag_q.pop_front();
    e = val_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic bus_write(input bit sel, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = {28'd0, a, 2'b00};
    di   = d;
    if (sel) we1 = 1'b1;
    else     we0 = 1'b1;
    @(negedge clk);
    we0 = 1'b0;
    we1 = 1'b0;
  endtask

  task automatic rd_chk(input bit sel, input logic [1:0] a, input string tag, input logic [31:0] e);
    sb_push(tag, e);
    @(negedge clk);
    addr = {28'd0, a, 2'b00};
    if (sel) re1 = 1'b1;
    else     re0 = 1'b1;
    @(negedge clk);
    re0 = 1'b0;
    re1 = 1'b0;
    sb_check(sel ? d1_do : d0_do);
  endtask

  function automatic logic cs_active(input bit sel);
    return sel ? (!d1_cs0_n || !d1_cs1_n) : (!d0_cs0_n || !d0_cs1_n);
  endfunction

  task automatic wait_idle(input bit sel, input int max);
    int n = 0;
    while (cs_active(sel) && n < max) begin
      @(negedge clk);
      n++;
    end
    sb_push("idle_reached", 32'd1);
    sb_check({31'd0, !cs_active(sel)});
    @(negedge clk);
  endtask

  task automatic snap0();
    rise_base = rises0; b_busy0 = busy0; b_cs0lo = cs0lo0; b_cs1lo = cs1lo0;
    b_m0hi = m0hi0; b_m1hi = m1hi0; b_edges0 = edges0;
  endtask

  task automatic snap1();
    b_busy1 = busy1; b_rises1 = rises1; b_sclkhi1 = sclkhi1;
  endtask

  initial begin
    int n;
    OPB_RST_N = 1'b0;
    addr = '0; di = '0;
    we0 = 1'b0; re0 = 1'b0; we1 = 1'b0; re1 = 1'b0;
    d1_miso1 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state: {cs0_n, cs1_n, sclk, mosi, irq} = 11000
    sb_push("rst_pins0", 32'h18);
    sb_check({27'd0, d0_cs0_n, d0_cs1_n, d0_sclk, d0_mosi0 | d0_mosi1, d0_irq});
    sb_push("rst_do0", 32'h0);
    sb_check(d0_do);
    sb_push("rst_pins1", 32'h18);
    sb_check({27'd0, d1_cs0_n, d1_cs1_n, d1_sclk, d1_mosi0 | d1_mosi1, d1_irq});
    OPB_RST_N = 1'b1;
    rd_chk(0, REG_STATUS, "status_rst", 32'h0);
    rd_chk(0, REG_CTRL, "ctrl_rst", 32'h0);

    // 8-bit loopback on SPI0
    bus_write(0, REG_TXDATA, 32'hA5);
    rx_pat = 32'h0;
    snap0();
    bus_write(0, REG_CTRL, 32'h0000_0701);
    wait_idle(0, 200);
    sb_push("t1_busy_cycles", 32'd72);   sb_check(32'(busy0 - b_busy0));
    sb_push("t1_mosi_bits", 32'hA5);     sb_check({24'd0, cap0[7:0]});
    sb_push("t1_sclk_rises", 32'd8);     sb_check(32'(rises0 - rise_base));
    sb_push("t1_cs1_low", 32'd0);        sb_check(32'(cs1lo0 - b_cs1lo));
    sb_push("t1_mosi1_high", 32'd0);     sb_check(32'(m1hi0 - b_m1hi));
    rd_chk(0, REG_STATUS, "t1_status_done", 32'h2);
    rd_chk(0, REG_RXDATA, "t1_rxdata", 32'h0000_00A5);
    rd_chk(0, REG_STATUS, "t1_done_cleared", 32'h0);

    // 32-bit transfer on SPI1 with an independent MISO pattern
    bus_write(0, REG_TXDATA, 32'hDEAD_BEEF);
    rx_pat = 32'h1234_5678;
    snap0();
    bus_write(0, REG_CTRL, 32'h0000_1F03);
    wait_idle(0, 400);
    sb_push("t2_busy_cycles", 32'd264);  sb_check(32'(busy0 - b_busy0));
    sb_push("t2_sclk_edges", 32'd64);    sb_check(32'(edges0 - b_edges0));
    sb_push("t2_mosi_bits", 32'hDEAD_BEEF); sb_check(cap0);
    sb_push("t2_cs0_low", 32'd0);        sb_check(32'(cs0lo0 - b_cs0lo));
    sb_push("t2_mosi0_high", 32'd0);     sb_check(32'(m0hi0 - b_m0hi));
    rd_chk(0, REG_STATUS, "t2_status_done", 32'h2);
    rd_chk(0, REG_RXDATA, "t2_rxdata", 32'h1234_5678);
    rx_pat = 32'h0;

    // IRQ and writes ignored while busy
    bus_write(0, REG_TXDATA, 32'h3C);
    snap0();
    bus_write(0, REG_CTRL, 32'h0000_0705);
    sb_push("t3_irq_while_busy", 32'd0); sb_check({31'd0, d0_irq});
    repeat (20) @(negedge clk);
    rd_chk(0, REG_STATUS, "t3_status_busy", 32'h1);
    bus_write(0, REG_CTRL, 32'h0000_0303);
    bus_write(0, REG_TXDATA, 32'hFF);
    wait_idle(0, 200);
    sb_push("t3_sclk_rises", 32'd8);     sb_check(32'(rises0 - rise_base));
    sb_push("t3_busy_cycles", 32'd72);   sb_check(32'(busy0 - b_busy0));
    sb_push("t3_cs1_low", 32'd0);        sb_check(32'(cs1lo0 - b_cs1lo));
    sb_push("t3_irq_done", 32'd1);       sb_check({31'd0, d0_irq});
    rd_chk(0, REG_CTRL, "t3_ctrl_kept", 32'h0000_0704);
    rd_chk(0, REG_TXDATA, "t3_tx_kept", 32'h3C);
    rd_chk(0, REG_RXDATA, "t3_rxdata", 32'h3C);
    sb_push("t3_irq_after_read", 32'd0); sb_check({31'd0, d0_irq});

    // RXDATA read landing on the completion edge
    bus_write(0, REG_TXDATA, 32'h81);
    snap0();
    bus_write(0, REG_CTRL, 32'h0000_0701);
    repeat (71) @(negedge clk);
    addr = {28'd0, REG_RXDATA, 2'b00};
    re0  = 1'b1;
    @(negedge clk);
    re0  = 1'b0;
    sb_push("t4_old_rxdata", 32'h3C);    sb_check(d0_do);
    sb_push("t4_cs_released", 32'd1);   sb_check({31'd0, d0_cs0_n});
    sb_push("t4_busy_cycles", 32'd72);   sb_check(32'(busy0 - b_busy0));
    rd_chk(0, REG_STATUS, "t4_done_kept", 32'h2);

    // Reset in the middle of a transfer
    bus_write(0, REG_TXDATA, 32'h5A);
    snap0();
    bus_write(0, REG_CTRL, 32'h0000_0701);
    n = 0;
    while ((rises0 - rise_base) < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    sb_push("t5_reached_bit3", 32'd1);   sb_check({31'd0, (rises0 - rise_base) >= 3});
    OPB_RST_N = 1'b0;
    @(negedge clk);
    sb_push("t5_rst_pins", 32'h18);
    sb_check({27'd0, d0_cs0_n, d0_cs1_n, d0_sclk, d0_mosi0 | d0_mosi1, d0_irq});
    sb_push("t5_rst_do", 32'h0);         sb_check(d0_do);
    OPB_RST_N = 1'b1;
    rd_chk(0, REG_STATUS, "t5_status", 32'h0);
    rd_chk(0, REG_RXDATA, "t5_rxdata", 32'h0);
    rd_chk(0, REG_CTRL, "t5_ctrl", 32'h0);
    rd_chk(0, REG_TXDATA, "t5_txdata", 32'h0);

    // CLK_DIV=1, single-bit transfer
    snap1();
    bus_write(1, REG_TXDATA, 32'h1);
    bus_write(1, REG_CTRL, 32'h0000_0001);
    wait_idle(1, 20);
    sb_push("t6_busy_cycles", 32'd4);    sb_check(32'(busy1 - b_busy1));
    sb_push("t6_sclk_rises", 32'd1);     sb_check(32'(rises1 - b_rises1));
    sb_push("t6_sclk_high", 32'd1);      sb_check(32'(sclkhi1 - b_sclkhi1));
    rd_chk(1, REG_RXDATA, "t6_rxdata", 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/app_spi_master.md
APP_SPI_MASTER -- requirements
Module: app_spi_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of OPB data and SPI shift registers.
REQ-002 SHALL have parameter CLK_DIV, default 4, OPB_CLK cycles per SCLK half-period (legal 1..255).
REQ-003 SHALL use one clock and a synchronous, active-low reset; no other clock or reset inputs.
REQ-004 OPB_CLK  in  1  sole clock; all logic on rising edge.
REQ-005 OPB_RST_N  in  1  synchronous active-low reset.
REQ-006 OPB_DI  in  32  write data.
REQ-007 OPB_DO  out  32  registered read data.
REQ-008 OPB_ADDR  in  32  byte address; only [3:2] decoded.
REQ-009 APP_RE / APP_WE  in  1 each  single-cycle read/write strobes.
REQ-010 APP_FPGA_SPI_CLK  out  1  shared SCLK, mode 0 (idle low).
REQ-011 APP_FPGA_SPI0_CS_N / APP_FPGA_SPI1_CS_N  out  1 each  active-low selects.
REQ-012 APP_FPGA_SPI0_MOSI / APP_FPGA_SPI1_MOSI  out  1 each  serial data out.
REQ-013 APP_FPGA_SPI0_MISO / APP_FPGA_SPI1_MISO  in  1 each  serial data in.
REQ-014 SPI_IRQ  out  1  level interrupt = DONE & IRQ_EN.

Function
REQ-015 Register map by OPB_ADDR[3:2]: 0 CTRL, 1 TXDATA, 2 RXDATA (RO), 3 STATUS (RO); writes to RO registers ignored.
REQ-016 CTRL: bit0 START (write-1 pulse, reads 0), bit1 CS_SEL (0=SPI0, 1=SPI1), bit2 IRQ_EN, bits[12:8] LEN; transfer length N = LEN+1 bits (1..32).
REQ-017 STATUS: bit0 BUSY, bit1 DONE (sticky); other bits read 0.
REQ-018 OPB_DO SHALL update on the edge after APP_RE is sampled high (1-cycle read latency) and hold its value otherwise.
REQ-019 FSM states IDLE -> CS_SETUP -> SHIFT_LO <-> SHIFT_HI -> CS_HOLD -> IDLE; each state lasts CLK_DIV cycles.
REQ-020 START write in IDLE: BUSY and selected CS_N assert on the next edge; CS_SETUP entered; CS_SEL, LEN and TXDATA latched.
REQ-021 SHIFT_LO: SCLK=0, selected MOSI = bit (N-1-i) of latched TXDATA (MSB first); SHIFT_HI: SCLK=1, selected MISO sampled into RX shift register on the SCLK rising edge cycle.
REQ-022 After bit N's SHIFT_HI, go to CS_HOLD with SCLK=0; at CS_HOLD end, CS_N deasserts, BUSY clears, DONE sets, RXDATA loads the N received bits right-aligned, upper bits 0.
REQ-023 BUSY SHALL be high for exactly CLK_DIV*(2N+2) cycles per transfer.
REQ-024 Unselected CS_N SHALL stay 1 and unselected MOSI SHALL stay 0 throughout.
REQ-025 START, CTRL and TXDATA writes while BUSY SHALL be ignored entirely.
REQ-026 Reading RXDATA clears DONE; if completion and the RXDATA read coincide, DONE SHALL end set and OPB_DO returns the old RXDATA.
REQ-027 Simultaneous APP_RE and APP_WE: both served; read returns the pre-write value.
REQ-028 Divider counter SHALL wrap at CLK_DIV-1 and be held at 0 in IDLE.

Reset
REQ-029 With OPB_RST_N low at an edge: state IDLE, both CS_N=1, SCLK=0, both MOSI=0, OPB_DO=0, CTRL/TXDATA/RXDATA=0, BUSY=DONE=0, SPI_IRQ=0.
REQ-030 Reset mid-transfer SHALL abort on that edge with no DONE and no RXDATA update.

Structure
REQ-031 Shared package app_if_pkg SHALL hold register offsets, CTRL/STATUS bit positions, and FSM state encoding.
REQ-032 One sub-module app_spi_clkgen SHALL produce the CLK_DIV phase tick; FSM, shifters and register file stay in app_spi_master.

Verification
REQ-033 CLK_DIV=4; TXDATA=0xA5, LEN=7, CS_SEL=0, MISO0 loops MOSI0 -> SPI0 MOSI shows 10100101, RXDATA=0x000000A5, BUSY 72 cycles, SPI1_CS_N stays 1.
REQ-034 LEN=31, CS_SEL=1, TXDATA=0xDEADBEEF, MISO1 driven 0x12345678 -> RXDATA=0x12345678, 64 SCLK edges, DONE=1.
REQ-035 START with IRQ_EN=1 then second START mid-transfer -> one transfer only; SPI_IRQ rises at completion, falls the cycle after RXDATA read.
REQ-036 OPB_RST_N low at bit 3 of a transfer -> next edge CS_N=1, SCLK=0, BUSY=0, DONE=0, RXDATA=0.
REQ-037 RXDATA read on the completion cycle -> OPB_DO = previous RXDATA, DONE remains 1.
REQ-038 CLK_DIV=1, LEN=0 -> BUSY exactly 4 cycles, one SCLK pulse one cycle wide.
